// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: state encodings, ALU control codes, defaults.
package alu_arb_pkg;

  localparam int W_DEF    = 8;
  localparam int NOPS_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  // Exactly one bit set (op selects are at most 32 bits wide).
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner select between two requesters.
// ALU_ARB_RR_EN defined: round-robin against the last grant; undefined: fixed req0 priority.
module alu_arb_pick (
  input  logic req0_i,
  input  logic req1_i,
`ifdef ALU_ARB_RR_EN
  input  logic last_i,
`endif
  output logic win_o,
  output logic any_o
);

  assign any_o = req0_i | req1_i;

  // win_o = 1 selects requester 1
  always_comb begin
    win_o = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (req0_i && req1_i) begin
      win_o = ~last_i;
    end else begin
      win_o = req1_i;
    end
`else
    if (req0_i) begin
      win_o = 1'b0;
    end else begin
      win_o = req1_i;
    end
`endif
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: grant, load operands, wait ALU_LAT cycles, return result.
// Build option ALU_ARB_RR_EN selects round-robin arbitration instead of fixed req0 priority.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int NOPS    = NOPS_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            on,
  input  logic            req0,
  input  logic [NOPS-1:0] op0,
  input  logic [W-1:0]    a0,
  input  logic [W-1:0]    b0,
  input  logic            req1,
  input  logic [NOPS-1:0] op1,
  input  logic [W-1:0]    a1,
  input  logic [W-1:0]    b1,
  output logic            done0,
  output logic            done1,
  output logic            err,
  output logic [W-1:0]    result,
  output logic [2:0]      alu_in_sel,
  output logic [W-1:0]    alu_num1,
  output logic [W-1:0]    alu_num2,
  output logic [NOPS-1:0] alu_out_sel,
  input  logic [W-1:0]    alu_out,
  output logic            busy,
  output logic [1:0]      curr_state
);

  localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

  state_e          state_q;
  logic            gnt_q;
  logic [2:0]      cnt_q;
  logic            done0_q;
  logic            done1_q;
  logic            err_q;
  logic [W-1:0]    result_q;
  logic [2:0]      in_sel_q;
  logic [W-1:0]    num1_q;
  logic [W-1:0]    num2_q;
  logic [NOPS-1:0] osel_q;
  logic            win_s;
  logic            any_s;
  logic [NOPS-1:0] win_op_s;
  logic [W-1:0]    win_a_s;
  logic [W-1:0]    win_b_s;
`ifdef ALU_ARB_RR_EN
  logic            last_q;
`endif

  alu_arb_pick u_pick (
    .req0_i (req0),
    .req1_i (req1),
`ifdef ALU_ARB_RR_EN
    .last_i (last_q),
`endif
    .win_o  (win_s),
    .any_o  (any_s)
  );

  assign win_op_s = win_s ? op1 : op0;
  assign win_a_s  = win_s ? a1  : a0;
  assign win_b_s  = win_s ? b1  : b0;

  // Operand/op latches double as the ALU drive registers; they change only on entering LOAD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      cnt_q    <= 3'd0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      in_sel_q <= SEL_RESET;
      num1_q   <= '0;
      num2_q   <= '0;
      osel_q   <= '0;
`ifdef ALU_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          in_sel_q <= SEL_PERSIST;
          if (on && any_s) begin
            gnt_q <= win_s;
            if (is_onehot(32'(win_op_s))) begin
              state_q  <= ST_LOAD;
              in_sel_q <= SEL_LOAD;
              num1_q   <= win_a_s;
              num2_q   <= win_b_s;
              osel_q   <= win_op_s;
            end else begin
              // Malformed op: skip the ALU entirely and complete with an error.
              state_q  <= ST_DONE;
              err_q    <= 1'b1;
              result_q <= '0;
              done0_q  <= ~win_s;
              done1_q  <= win_s;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          in_sel_q <= SEL_PERSIST;
          cnt_q    <= 3'd0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          in_sel_q <= SEL_PERSIST;
          if (cnt_q == LAT_M1) begin
            result_q <= alu_out;
            done0_q  <= ~gnt_q;
            done1_q  <= gnt_q;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_DONE: begin
          in_sel_q <= SEL_PERSIST;
          state_q  <= ST_IDLE;
`ifdef ALU_ARB_RR_EN
          last_q   <= gnt_q;
`endif
        end
        default: begin
          in_sel_q <= SEL_PERSIST;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign done0       = done0_q;
  assign done1       = done1_q;
  assign err         = err_q;
  assign result      = result_q;
  assign alu_in_sel  = in_sel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_out_sel = osel_q;
  assign busy        = (state_q != ST_IDLE);
  assign curr_state  = state_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: transaction-level reference model plus directed and random stimulus.
module tb_alu_req_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst, on, req0, req1;
  logic [6:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       done0, done1, err, busy;
  logic [7:0] result, alu_num1, alu_num2, alu_out;
  logic [2:0] alu_in_sel;
  logic [6:0] alu_out_sel;
  logic [1:0] curr_state;

  logic       rst_3, on_3, req0_3, req1_3;
  logic [6:0] op0_3, op1_3;
  logic [7:0] a0_3, b0_3, a1_3, b1_3;
  logic       done0_3, done1_3, err_3, busy_3;
  logic [7:0] result_3, alu_num1_3, alu_num2_3, alu_out_3;
  logic [2:0] alu_in_sel_3;
  logic [6:0] alu_out_sel_3;
  logic [1:0] curr_state_3;

  alu_req_arbiter #(.W(8), .NOPS(7), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .on(on),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .err(err), .result(result),
    .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_out(alu_out), .busy(busy), .curr_state(curr_state)
  );

  alu_req_arbiter #(.W(8), .NOPS(7), .ALU_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst(rst_3), .on(on_3),
    .req0(req0_3), .op0(op0_3), .a0(a0_3), .b0(b0_3),
    .req1(req1_3), .op1(op1_3), .a1(a1_3), .b1(b1_3),
    .done0(done0_3), .done1(done1_3), .err(err_3), .result(result_3),
    .alu_in_sel(alu_in_sel_3), .alu_num1(alu_num1_3), .alu_num2(alu_num2_3),
    .alu_out_sel(alu_out_sel_3), .alu_out(alu_out_3), .busy(busy_3), .curr_state(curr_state_3)
  );

  function automatic logic [7:0] alu_f(input logic [6:0] sel, input logic [7:0] x, input logic [7:0] y);
    if (sel == 7'b1000000) return x + y;
    else if (sel == 7'b0100000) return x & y;
    else return x ^ y;
  endfunction

  // Bench ALUs: result is valid exactly LAT cycles after the load cycle, inverted garbage otherwise.
  logic [7:0] alu_val, alu_val3;
  int alu_age = 0, alu_age3 = 0;
  always @(posedge clk) begin
    if (alu_in_sel == 3'b010) begin
      alu_val <= alu_f(alu_out_sel, alu_num1, alu_num2);
      alu_age <= 1;
    end else if (alu_age != 0 && alu_age < 15) begin
      alu_age <= alu_age + 1;
    end
  end
  assign alu_out = (alu_age == LAT) ? alu_val : ~alu_val;

  always @(posedge clk) begin
    if (alu_in_sel_3 == 3'b010) begin
      alu_val3 <= alu_f(alu_out_sel_3, alu_num1_3, alu_num2_3);
      alu_age3 <= 1;
    end else if (alu_age3 != 0 && alu_age3 < 15) begin
      alu_age3 <= alu_age3 + 1;
    end
  end
  assign alu_out_3 = (alu_age3 == LAT3) ? alu_val3 : ~alu_val3;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: one transaction at a time, indexed by cycles since the grant edge.
  int         m_act = 0, m_t = 0, m_last = 0, m_who = 0, m_ptr = 1;
  bit         m_bad = 1'b0, m_valid = 1'b0;
  logic [6:0] m_op;
  logic [7:0] m_a, m_b;
  logic [1:0] e_state;
  logic [2:0] e_in_sel;
  logic       e_busy, e_done0, e_done1, e_err;
  logic [7:0] e_result, e_num1, e_num2;
  logic [6:0] e_osel;

  task automatic model_step();
    if (!rst) begin
      m_act = 0; m_ptr = 1;
      e_state = 2'd0; e_in_sel = 3'b001; e_busy = 1'b0;
      e_done0 = 1'b0; e_done1 = 1'b0; e_err = 1'b0; e_result = 8'd0;
      e_num1 = 8'd0; e_num2 = 8'd0; e_osel = 7'd0;
    end else begin
      e_done0 = 1'b0; e_done1 = 1'b0; e_err = 1'b0;
      if (m_act != 0 && m_t < m_last) begin
        m_t++;
      end else if (m_act != 0) begin
        m_act = 0;
      end else if (on && (req0 || req1)) begin
        if (req0 && req1) begin
`ifdef ALU_ARB_RR_EN
          m_who = (m_ptr == 1) ? 0 : 1;
`else
          m_who = 0;
`endif
        end else begin
          m_who = req1 ? 1 : 0;
        end
        m_op   = (m_who == 1) ? op1 : op0;
        m_a    = (m_who == 1) ? a1 : a0;
        m_b    = (m_who == 1) ? b1 : b0;
        m_bad  = ($countones(m_op) != 1);
        m_last = m_bad ? 1 : 2 + LAT;
        m_act  = 1;
        m_t    = 1;
      end
      if (m_act == 0) begin
        e_state = 2'd0; e_in_sel = 3'b100; e_busy = 1'b0;
      end else begin
        e_busy = 1'b1;
        if (m_t == m_last) begin
          e_state = 2'd3; e_in_sel = 3'b100;
          e_done0 = (m_who == 0); e_done1 = (m_who == 1);
          e_err = m_bad;
          e_result = m_bad ? 8'd0 : alu_f(m_op, m_a, m_b);
          m_ptr = m_who;
        end else if (m_t == 1) begin
          e_state = 2'd1; e_in_sel = 3'b010;
          e_num1 = m_a; e_num2 = m_b; e_osel = m_op;
        end else begin
          e_state = 2'd2; e_in_sel = 3'b100;
        end
      end
    end
  endtask

  // Compare every cycle on the falling edge, then advance the model using the inputs the next edge sees.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("m_state", curr_state, e_state);
        check("m_in_sel", alu_in_sel, e_in_sel);
        check("m_busy", busy, e_busy);
        check("m_done0", done0, e_done0);
        check("m_done1", done1, e_done1);
        check("m_err", err, e_err);
        check("m_result", result, e_result);
        check("m_num1", alu_num1, e_num1);
        check("m_num2", alu_num2, e_num2);
        check("m_osel", alu_out_sel, e_osel);
      end
      model_step();
      m_valid = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(output int n, output bit saw_load);
    bit got;
    got = 1'b0; n = 0; saw_load = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      n++;
      if (alu_in_sel == 3'b010) saw_load = 1'b1;
      if (done0 || done1) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL wait_done got=no_done exp=done_within_30");
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] one;
    one = 7'b0000001 << $urandom_range(0, 6);
    case ($urandom_range(0, 5))
      0, 1:    return 7'b1000000;
      2, 3:    return 7'b0100000;
      4:       return one;
      default: return 7'($urandom);
    endcase
  endfunction

  int n;
  bit sl, first1, saw_busy, stable;
  int wait_cyc;
  logic [7:0] s_n1, s_n2;
  logic [6:0] s_os;

  initial begin
    rst = 1'b0; on = 1'b0; req0 = 1'b0; req1 = 1'b0;
    op0 = 7'b1000000; a0 = 8'h57; b0 = 8'h1A;
    op1 = 7'b0100000; a1 = 8'h57; b1 = 8'h1A;
    rst_3 = 1'b0; on_3 = 1'b0; req0_3 = 1'b0; req1_3 = 1'b0;
    op0_3 = 7'b0100000; a0_3 = 8'h57; b0_3 = 8'h1A;
    op1_3 = 7'd0; a1_3 = 8'd0; b1_3 = 8'd0;
    tick(); tick();
    check("rst_state", curr_state, 2'b00);
    check("rst_in_sel", alu_in_sel, 3'b001);
    check("rst_busy", busy, 1'b0);
    check("rst_done", {done0, done1, err}, 3'b000);
    check("rst_result", result, 8'h00);
    check("rst_ops", {alu_num1, alu_num2, alu_out_sel}, 23'd0);
    rst = 1'b1; rst_3 = 1'b1;
    tick();

    // Contention from reset: req0 first, then req1
    on = 1'b1; req0 = 1'b1; req1 = 1'b1;
    wait_done(n, sl);
    check("cont_done0", {done0, done1}, 2'b10);
    check("cont_res0", result, 8'h71);
    check("cont_lat0", n, 3);
    req0 = 1'b0;
    wait_done(n, sl);
    check("cont_done1", {done0, done1}, 2'b01);
    check("cont_res1", result, 8'h12);
    check("cont_lat1", n, 4);
    req1 = 1'b0;
    tick();

    // Single op
    req0 = 1'b1;
    tick();
    check("single_load_sel", alu_in_sel, 3'b010);
    check("single_load_n1", alu_num1, 8'h57);
    req0 = 1'b0;
    wait_done(n, sl);
    check("single_done0", done0, 1'b1);
    check("single_res", result, 8'h71);
    check("single_err", err, 1'b0);
    check("single_lat", n + 1, 3);
    tick();

    // Invalid op
    op0 = 7'b1100000; req0 = 1'b1;
    wait_done(n, sl);
    check("inv_done0", done0, 1'b1);
    check("inv_err", err, 1'b1);
    check("inv_res", result, 8'h00);
    check("inv_no_load", sl, 1'b0);
    check("inv_lat", n, 1);
    req0 = 1'b0; op0 = 7'b1000000;
    tick();

    // Repeated contention: last grant was req0
`ifdef ALU_ARB_RR_EN
    first1 = 1'b1;
`else
    first1 = 1'b0;
`endif
    req0 = 1'b1; req1 = 1'b1;
    wait_done(n, sl);
    check("rep_first_done1", done1, first1);
    check("rep_first_res", result, first1 ? 8'h12 : 8'h71);
    if (first1) req1 = 1'b0; else req0 = 1'b0;
    wait_done(n, sl);
    check("rep_second_done1", done1, !first1);
    check("rep_second_res", result, first1 ? 8'h71 : 8'h12);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Enable gating
    on = 1'b0; req1 = 1'b1; saw_busy = 1'b0;
    repeat (3) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    check("gate_busy", saw_busy, 1'b0);
    on = 1'b1;
    tick();
    check("gate_grant", curr_state, 2'b01);
    on = 1'b0;
    wait_done(n, sl);
    check("gate_done1", done1, 1'b1);
    check("gate_res", result, 8'h12);
    req1 = 1'b0; on = 1'b1;
    tick();

    // Reset mid-op, request still held afterwards
    req0 = 1'b1;
    tick(); tick();
    check("mid_wait", curr_state, 2'b10);
    rst = 1'b0;
    tick();
    check("mid_rst_state", curr_state, 2'b00);
    check("mid_rst_sel", alu_in_sel, 3'b001);
    check("mid_rst_done", done0, 1'b0);
    rst = 1'b1;
    wait_done(n, sl);
    check("mid_redo_done0", done0, 1'b1);
    check("mid_redo_res", result, 8'h71);
    check("mid_redo_lat", n, 3);
    req0 = 1'b0;
    tick();

    // Random traffic against the model
    for (int it = 0; it < 3000; it++) begin
      tick();
      rst = ($urandom_range(0, 199) != 0);
      on  = ($urandom_range(0, 7) != 0);
      if (req0) begin
        if (e_done0) req0 = ($urandom_range(0, 7) == 0);
        else if ($urandom_range(0, 29) == 0) req0 = 1'b0;
        else if ($urandom_range(0, 3) == 0) begin op0 = rand_op(); a0 = 8'($urandom); b0 = 8'($urandom); end
      end else if ($urandom_range(0, 2) == 0) begin
        req0 = 1'b1; op0 = rand_op(); a0 = 8'($urandom); b0 = 8'($urandom);
      end
      if (req1) begin
        if (e_done1) req1 = ($urandom_range(0, 7) == 0);
        else if ($urandom_range(0, 29) == 0) req1 = 1'b0;
        else if ($urandom_range(0, 3) == 0) begin op1 = rand_op(); a1 = 8'($urandom); b1 = 8'($urandom); end
      end else if ($urandom_range(0, 2) == 0) begin
        req1 = 1'b1; op1 = rand_op(); a1 = 8'($urandom); b1 = 8'($urandom);
      end
    end
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();

    // ALU_LAT = 3 instance
    on_3 = 1'b1; req0_3 = 1'b1;
    n = 0; wait_cyc = 0; stable = 1'b1;
    s_n1 = 8'd0; s_n2 = 8'd0; s_os = 7'd0;
    for (int k = 0; k < 30 && !done0_3; k++) begin
      tick();
      n++;
      if (curr_state_3 == 2'b01) begin
        s_n1 = alu_num1_3; s_n2 = alu_num2_3; s_os = alu_out_sel_3;
      end
      if (curr_state_3 == 2'b10) begin
        wait_cyc++;
        if (alu_num1_3 != s_n1 || alu_num2_3 != s_n2 || alu_out_sel_3 != s_os) stable = 1'b0;
      end
    end
    req0_3 = 1'b0;
    check("lat3_done0", done0_3, 1'b1);
    check("lat3_lat", n, 5);
    check("lat3_res", result_3, 8'h12);
    check("lat3_err", err_3, 1'b0);
    check("lat3_wait_cycles", wait_cyc, 3);
    check("lat3_stable", stable, 1'b1);
    check("lat3_snap", {s_n1, s_n2, s_os}, {8'h57, 8'h1A, 7'b0100000});
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one 8-bit ALU (the `main` datapath) between two requesters.
- Arbitrates requests and drives the ALU's operands, one-hot op select and load/persist/reset control.
- Waits a fixed ALU latency, then returns the captured result to the granted requester with a one-cycle done pulse.
- Sits between requester logic and the ALU; the ALU itself is unchanged.

Parameters:
- W, 8: operand/result width.
- NOPS, 7: width of the one-hot op select.
- ALU_LAT, 1: cycles from the LOAD cycle to a valid alu_out (range 1..7).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- on  input  1  enable; when 0, no new grants are made, but an in-flight op completes.
- req0  input  1  requester 0 request; held high until done0.
- op0  input  NOPS  requester 0 one-hot op select.
- a0, b0  input  W  requester 0 operands.
- req1, op1, a1, b1  as above, for requester 1.
- done0, done1  output  1  one-cycle completion pulse to the granted requester.
- err  output  1  valid with done*; high when the op was not one-hot.
- result  output  W  valid with done*; holds its value until the next done.
- alu_in_sel  output  3  ALU control: 3'b100 persist, 3'b010 load, 3'b001 reset.
- alu_num1, alu_num2  output  W  ALU operands.
- alu_out_sel  output  NOPS  ALU op select.
- alu_out  input  W  ALU result.
- busy  output  1  high in any state other than IDLE.
- curr_state  output  2  state register, for debug.

Behaviour:
- Reset: rst sampled low at a clk edge gives, next cycle:
  - state IDLE; done0 = done1 = err = 0; result = 0.
  - alu_in_sel = 3'b001; alu_num1 = alu_num2 = 0; alu_out_sel = 0; busy = 0; last-grant pointer = 1.
  - Reset mid-operation abandons the op with no done pulse. Requests still high after release are re-arbitrated.
- State encoding: IDLE = 2'b00, LOAD = 2'b01, WAIT = 2'b10, DONE = 2'b11.
- IDLE:
  - alu_in_sel = 3'b100.
  - If on = 1 and any req is high: pick the winner, latch its op/a/b, and go to LOAD. Otherwise stay.
- Invalid op:
  - If the latched op is not exactly one-hot (zero or more than one bit set), go directly to DONE with err = 1 and result = 0.
  - The ALU is not loaded and alu_in_sel stays 3'b100.
- LOAD (exactly 1 cycle):
  - Drive alu_in_sel = 3'b010, alu_num1/alu_num2 = latched operands, alu_out_sel = latched op.
  - Clear the latency counter; go to WAIT.
- WAIT:
  - alu_in_sel = 3'b100; operands and op select held stable.
  - Counter increments each cycle. When counter = ALU_LAT-1, capture alu_out into result and go to DONE.
- DONE (1 cycle):
  - Assert done of the granted requester; err as determined; update the last-grant pointer; go to IDLE.
- Latency: request seen in IDLE → done asserted in cycle 2 + ALU_LAT after the grant edge. With ALU_LAT = 1, done occurs 3 cycles after grant.
- Back-to-back: at least one IDLE cycle between ops. The requester must drop req the cycle after done, or it is re-served.
- Request timing: op/a/b are sampled only at the grant. Changes afterwards are ignored; req dropped before done is ignored (the op still completes).
- Arbitration without ALU_ARB_RR_EN: fixed priority, req0 wins. When both are high, req1 is served only after req0 drops.

Optional Feature:
- Macro: ALU_ARB_RR_EN.
- Defined: round-robin. On simultaneous requests, the requester not granted last wins; the pointer updates in DONE, including error completions.
- Undefined: fixed priority, req0 over req1; the pointer register is omitted.

Decomposition:
- Package alu_arb_pkg:
  - state encodings (IDLE/LOAD/WAIT/DONE);
  - alu_in_sel constants (SEL_PERSIST = 3'b100, SEL_LOAD = 3'b010, SEL_RESET = 3'b001);
  - W and NOPS defaults.
- One sub-module: alu_arb_pick. Combinational winner select from req0, req1 and the last-grant pointer; it holds the feature-macro branching. The FSM and datapath latches stay in the top module.

Test Plan:
Bench ALU model: num1 + num2 for out_sel 7'b1000000, num1 & num2 for 7'b0100000; ALU_LAT = 1.
- Single op: req0 with a0 = 8'h57, b0 = 8'h1A, op0 = 7'b1000000 → LOAD drives alu_in_sel = 3'b010; done0 3 cycles after grant; result = 8'h71; err = 0.
- Contention: req0 and req1 rise together (op1 = 7'b0100000, a1 = 8'h57, b1 = 8'h1A); both hold until their done.
  - Without the macro: req0 served first, then req1 gets result = 8'h12.
  - With the macro and pointer = 1: same order. A repeated contention then grants req1 first.
- Invalid op: op0 = 7'b1100000 → alu_in_sel never 3'b010; done0 with err = 1 and result = 8'h00.
- Enable gating: on = 0 with req1 high → busy stays 0 and no grant. Raising on → grant next cycle. Dropping on during WAIT → op still completes.
- Reset mid-op: rst = 0 during WAIT → next cycle curr_state = 2'b00, alu_in_sel = 3'b001, no done pulse; req still high after release → re-served with the correct result.
- Latency parameter: ALU_LAT = 3 → done exactly 5 cycles after grant; alu_num1/alu_num2/alu_out_sel stable throughout WAIT.
